cr_kme_fifo_tx_packer: RTL and testbench
========================================

// Module: cr_kme_fifo_tx_packer
// PURPOSE
//  Write-side feeder for the KME 83-bit stall-based FIFO. Packs a 32-bit valid/ready beat
//  stream into 64-bit entries {tag[8:0],sop,eop,bmask[7:0],data[63:0]} and drives
//  fifo_in/fifo_in_valid. The FIFO write port has no back-pressure of its own, so this block
//  writes only when fifo_in_stall is low and must never cause an overflow.
// PARAMETERS
//  CNT_W   16  width of the emitted-packet counter pkt_cnt (saturating)
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   asynchronous active-low reset
//  s_valid         in   1   input beat valid
//  s_ready         out  1   input beat accepted when s_valid & s_ready
//  s_data          in   32  beat data, byte 0 in [7:0]
//  s_sop           in   1   first beat of packet; s_tag sampled on this beat
//  s_eop           in   1   last beat of packet
//  s_bytes         in   2   valid bytes on eop beat (0 = 4, 1..3 = 1..3); ignored otherwise
//  s_tag           in   9   packet tag
//  fifo_in         out  83  entry to FIFO
//  fifo_in_valid   out  1   FIFO write enable
//  fifo_in_stall   in   1   FIFO full; no write permitted this cycle
//  pkt_err         out  1   one-cycle pulse on protocol violation
//  pkt_cnt         out  CNT_W  packets fully written (eop entry written)
// BEHAVIOUR
//  Reset: s_ready=1, fifo_in=0, fifo_in_valid=0, pkt_err=0, pkt_cnt=0; state IDLE; holding
//   register empty; accumulator and saved tag/sop cleared. Reset mid-packet discards all data.
//  States: IDLE (outside packet), LO (in packet, expect low half), HI (low half held).
//   IDLE --sop&~eop--> HI; IDLE --sop&eop--> IDLE (single-beat entry emitted).
//   HI --beat--> LO (entry emitted) or IDLE if eop. LO --beat,~eop--> HI; LO --eop--> IDLE.
//  Entry assembly: low beat -> data[31:0], bmask[3:0]; high beat -> data[63:32], bmask[7:4].
//   Non-eop beat: 4 bytes valid. Eop beat: bytes >= s_bytes forced 0 in data and bmask.
//   Eop on a low beat emits immediately with data[63:32]=0, bmask[7:4]=0.
//   sop bit = 1 only on first entry of packet; eop bit = 1 only on last; tag = sampled s_tag
//   on every entry of the packet.
//  Holding register (one entry): loaded when an entry completes; fifo_in_valid =
//   hold_vld & ~fifo_in_stall; fifo_in driven from register (stable while held). Entry
//   retires the cycle it is written. Latency: completing beat at cycle N -> write at N+1 at
//   earliest.
//  s_ready = ~hold_vld | ~fifo_in_stall (load and drain in same cycle allowed). Beat that
//   does not complete an entry (low half, non-eop) is also gated by this rule.
//  fifo_in_valid never asserted while fifo_in_stall=1 (overflow impossible by construction).
//  Protocol errors (pkt_err pulses cycle after acceptance): sop while in LO/HI -> current
//   partial discarded, new packet started; non-sop beat in IDLE -> beat dropped.
//  pkt_cnt increments on write of eop entry; saturates at all-ones.
// TESTING
//  1) 4-beat pkt tag=0x15, stall=0 -> 2 writes: {0x15,1,0,0xFF,..},{0x15,0,1,0xFF,..}; pkt_cnt=1.
//  2) 3-beat pkt, s_bytes=2 on eop -> 2nd entry bmask=0x03, data[63:16]=0, eop=1.
//  3) Single beat sop&eop s_bytes=0 -> one entry sop=1,eop=1,bmask=0x0F, data[63:32]=0.
//  4) Hold stall=1 for 10 cycles with entry pending -> fifo_in_valid=0, s_ready=0, fifo_in
//     stable; release -> write next cycle, no beat lost.
//  5) Back-to-back 2-beat pkts, stall=0 -> one write every 2 cycles, s_ready continuously 1.
//  6) sop mid-packet -> pkt_err pulse, partial dropped; data beat in IDLE -> pkt_err, no write;
//     rst_n low mid-packet -> all outputs to reset values immediately.

Source files
------------

// File: rtl/cr_kme_fifo_tx_packer.sv
// -----------------------------------------------------------------------------
// cr_kme_fifo_tx_packer
//
// Write-side feeder for the KME 83-bit stall-based FIFO. Two 32-bit input beats
// are packed into one 64-bit entry laid out as
//   {tag[8:0], sop, eop, bmask[7:0], data[63:0]}
// and presented to the FIFO from a single-entry holding register. The FIFO
// write port has no back-pressure beyond fifo_in_stall, so a write is only
// issued while fifo_in_stall is low; an entry is retired the cycle it is
// written.
//
// Parameters
//   CNT_W          width of the saturating emitted-packet counter
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   s_valid        input beat valid
//   s_ready        input beat accepted when s_valid & s_ready
//   s_data         beat data, byte 0 in [7:0]
//   s_sop          first beat of packet; s_tag sampled on this beat
//   s_eop          last beat of packet
//   s_bytes        valid bytes on eop beat (0 = 4, 1..3 = 1..3)
//   s_tag          packet tag
//   fifo_in        entry to FIFO (driven from the holding register)
//   fifo_in_valid  FIFO write enable
//   fifo_in_stall  FIFO full; no write permitted this cycle
//   pkt_err        one-cycle pulse on protocol violation
//   pkt_cnt        packets whose eop entry has been written (saturating)
// -----------------------------------------------------------------------------
module cr_kme_fifo_tx_packer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_sop,
    input  logic             s_eop,
    input  logic [1:0]       s_bytes,
    input  logic [8:0]       s_tag,
    output logic [82:0]      fifo_in,
    output logic             fifo_in_valid,
    input  logic             fifo_in_stall,
    output logic             pkt_err,
    output logic [CNT_W-1:0] pkt_cnt
);

    // Packer states: outside a packet, expecting the low half of an entry,
    // or holding the low half and expecting the high half.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;

    // Bit position of the eop flag inside an entry.
    localparam int unsigned EOP_BIT = 72;

    logic [1:0]       state_q,    state_d;
    logic [31:0]      acc_data_q, acc_data_d;
    logic [3:0]       acc_mask_q, acc_mask_d;
    logic [8:0]       tag_q,      tag_d;
    logic             sop_pend_q, sop_pend_d;
    logic [82:0]      hold_q,     hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             err_q,      err_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic        accept;
    logic        drain;
    logic        emit;
    logic [82:0] entry;
    logic [2:0]  nbytes;
    logic [3:0]  beat_mask;
    logic [31:0] beat_data;

    // Holding register drains whenever it is full and the FIFO can take a
    // write; a new entry may be loaded in that same cycle.
    assign drain   = hold_vld_q & ~fifo_in_stall;
    assign s_ready = ~hold_vld_q | ~fifo_in_stall;
    assign accept  = s_valid & s_ready;

    // Byte qualification of the incoming beat: all four bytes are valid
    // unless this is the eop beat with a partial byte count.
    always_comb begin
        nbytes = 3'd4;
        if (s_eop && (s_bytes != 2'd0)) begin
            nbytes = {1'b0, s_bytes};
        end
        beat_mask = '0;
        beat_data = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            beat_mask[i] = (3'(i) < nbytes);
            if (beat_mask[i]) begin
                beat_data[8*i +: 8] = s_data[8*i +: 8];
            end
        end
    end

    // Packet framing and entry assembly.
    always_comb begin
        state_d    = state_q;
        acc_data_d = acc_data_q;
        acc_mask_d = acc_mask_q;
        tag_d      = tag_q;
        sop_pend_d = sop_pend_q;
        err_d      = 1'b0;
        emit       = 1'b0;
        entry      = '0;

        if (accept) begin
            if (s_sop) begin
                // A sop inside a packet abandons the held low half and
                // restarts framing from this beat.
                err_d = (state_q != ST_IDLE);
                tag_d = s_tag;
                if (s_eop) begin
                    emit       = 1'b1;
                    entry      = {s_tag, 1'b1, 1'b1, 4'h0, beat_mask,
                                  32'h0, beat_data};
                    sop_pend_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    acc_data_d = beat_data;
                    acc_mask_d = beat_mask;
                    sop_pend_d = 1'b1;
                    state_d    = ST_HI;
                end
            end else begin
                case (state_q)
                    ST_HI: begin
                        emit       = 1'b1;
                        entry      = {tag_q, sop_pend_q, s_eop,
                                      beat_mask, acc_mask_q,
                                      beat_data, acc_data_q};
                        sop_pend_d = 1'b0;
                        state_d    = s_eop ? ST_IDLE : ST_LO;
                    end
                    ST_LO: begin
                        if (s_eop) begin
                            // Packet ends on a low half: upper half is empty.
                            emit       = 1'b1;
                            entry      = {tag_q, sop_pend_q, 1'b1,
                                          4'h0, beat_mask,
                                          32'h0, beat_data};
                            sop_pend_d = 1'b0;
                            state_d    = ST_IDLE;
                        end else begin
                            acc_data_d = beat_data;
                            acc_mask_d = beat_mask;
                            state_d    = ST_HI;
                        end
                    end
                    default: begin
                        // Data beat outside a packet is dropped.
                        err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // Holding register and packet counter. A load can never land on an
    // undrained entry because accept already requires s_ready.
    always_comb begin
        hold_vld_d = emit | (hold_vld_q & ~drain);
        hold_d     = emit ? entry : hold_q;
        cnt_d      = cnt_q;
        if (drain && hold_q[EOP_BIT] && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_data_q <= '0;
            acc_mask_q <= '0;
            tag_q      <= '0;
            sop_pend_q <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_data_q <= acc_data_d;
            acc_mask_q <= acc_mask_d;
            tag_q      <= tag_d;
            sop_pend_q <= sop_pend_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign fifo_in       = hold_q;
    assign fifo_in_valid = drain;
    assign pkt_err       = err_q;
    assign pkt_cnt       = cnt_q;

endmodule

// File: tb/tb_cr_kme_fifo_tx_packer.sv
// -----------------------------------------------------------------------------
// tb_cr_kme_fifo_tx_packer
//
// Directed and randomized stimulus for cr_kme_fifo_tx_packer. Expected FIFO
// entries are derived per packet from its beat list (byte-by-byte placement
// into 64-bit entries) and compared in order against observed writes.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. The counter width is narrowed so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_cr_kme_fifo_tx_packer;

    localparam int unsigned CW      = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          s_sop;
    logic          s_eop;
    logic [1:0]    s_bytes;
    logic [8:0]    s_tag;
    logic [82:0]   fifo_in;
    logic          fifo_in_valid;
    logic          fifo_in_stall;
    logic          pkt_err;
    logic [CW-1:0] pkt_cnt;

    cr_kme_fifo_tx_packer #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_sop         (s_sop),
        .s_eop         (s_eop),
        .s_bytes       (s_bytes),
        .s_tag         (s_tag),
        .fifo_in       (fifo_in),
        .fifo_in_valid (fifo_in_valid),
        .fifo_in_stall (fifo_in_stall),
        .pkt_err       (pkt_err),
        .pkt_cnt       (pkt_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stall_pct = 0;
    int exp_pkts = 0;
    int exp_err = 0;
    int err_seen = 0;
    bit exp_rdy = 1'b0;

    logic [82:0] exp_q[$];
    int          wr_cyc[$];
    logic [31:0] pd[16];

    task automatic chk(input string tag, input logic [82:0] got, input logic [82:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every write must be the next expected entry, and no
    // write may appear while the FIFO is stalling.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (fifo_in_stall) chk("no_write_in_stall", 83'(fifo_in_valid), 83'(0));
            if (fifo_in_valid === 1'b1) begin
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", fifo_in, 83'h0 - 83'h1);
                end else begin
                    chk("entry", fifo_in, exp_q.pop_front());
                end
            end
            if (pkt_err === 1'b1) err_seen++;
        end
    end

    // Advance one cycle; inputs settle 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        fifo_in_stall = ($urandom_range(99) < stall_pct);
    endtask

    // Expected entries for a packet whose beats are pd[0..n-1]. An
    // incomplete packet yields only its fully paired entries.
    task automatic model_push(input int n, input logic [8:0] tag,
                              input logic [1:0] bytes, input bit complete);
        int nent;
        int last_bytes;
        nent = complete ? (n + 1) / 2 : n / 2;
        last_bytes = (bytes == 2'd0) ? 4 : int'(bytes);
        for (int e = 0; e < nent; e++) begin
            logic [63:0] d;
            logic [7:0]  m;
            logic        sop;
            logic        eop;
            d = '0;
            m = '0;
            for (int b = 0; b < 8; b++) begin
                int beat;
                int byt;
                beat = 2 * e + b / 4;
                byt  = b % 4;
                if (beat < n && !(complete && beat == n - 1 && byt >= last_bytes)) begin
                    d[8*b +: 8] = pd[beat][8*byt +: 8];
                    m[b] = 1'b1;
                end
            end
            sop = (e == 0);
            eop = complete && (e == nent - 1);
            exp_q.push_back({tag, sop, eop, m, d});
        end
        if (complete) exp_pkts++;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic sop, input logic eop, input logic [1:0] bytes,
                        input logic [8:0] tag, input logic [31:0] data);
        int waited;
        s_valid = 1'b1;
        s_sop   = sop;
        s_eop   = eop;
        s_bytes = bytes;
        s_tag   = tag;
        s_data  = data;
        waited  = 0;
        @(negedge clk);
        if (exp_rdy) chk("ready_b2b", 83'(s_ready), 83'(1));
        while (s_ready !== 1'b1 && waited < 300) begin
            tick();
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) chk("accept_timeout", 83'(s_ready), 83'(1));
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [8:0] tag,
                            input logic [1:0] bytes, input bit complete);
        for (int i = 0; i < n; i++) pd[i] = $urandom;
        model_push(n, tag, bytes, complete);
        for (int i = 0; i < n; i++) begin
            send(i == 0, complete && (i == n - 1), bytes, tag, pd[i]);
        end
    endtask

    task automatic drain_check(input string tag);
        int w;
        stall_pct = 0;
        fifo_in_stall = 1'b0;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            tick();
            w++;
        end
        tick();
        tick();
        chk({tag, "_drained"}, 83'(exp_q.size()), 83'(0));
        chk({tag, "_pkt_cnt"}, 83'(pkt_cnt),
            83'((exp_pkts > int'(CNT_MAX)) ? int'(CNT_MAX) : exp_pkts));
        chk({tag, "_err_cnt"}, 83'(err_seen), 83'(exp_err));
    endtask

    initial begin
        logic [82:0] saved;
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_sop = 1'b0;
        s_eop = 1'b0;
        s_bytes = '0;
        s_tag = '0;
        s_data = '0;
        fifo_in_stall = 1'b0;
        saved = '0;

        // Reset values
        @(negedge clk);
        chk("rst_s_ready", 83'(s_ready), 83'(1));
        chk("rst_fifo_in", fifo_in, 83'(0));
        chk("rst_valid", 83'(fifo_in_valid), 83'(0));
        chk("rst_pkt_err", 83'(pkt_err), 83'(0));
        chk("rst_pkt_cnt", 83'(pkt_cnt), 83'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 4-beat packet, full bytes
        send_pkt(4, 9'h015, 2'd0, 1'b1);
        drain_check("t1");

        // 3-beat packet, 2 valid bytes on eop
        send_pkt(3, 9'h0a3, 2'd2, 1'b1);
        drain_check("t2");

        // Single-beat packet
        send_pkt(1, 9'h1ff, 2'd0, 1'b1);
        drain_check("t3");

        // Stall with an entry pending
        stall_pct = 100;
        fifo_in_stall = 1'b1;
        for (int i = 0; i < 4; i++) pd[i] = $urandom;
        model_push(4, 9'h042, 2'd0, 1'b1);
        send(1'b1, 1'b0, 2'd0, 9'h042, pd[0]);
        send(1'b0, 1'b0, 2'd0, 9'h042, pd[1]);
        s_valid = 1'b1;
        s_sop = 1'b0;
        s_eop = 1'b0;
        s_data = pd[2];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 83'(fifo_in_valid), 83'(0));
            chk("stall_ready", 83'(s_ready), 83'(0));
            if (i == 0) saved = fifo_in;
            else chk("stall_stable", fifo_in, saved);
            tick();
        end
        stall_pct = 0;
        fifo_in_stall = 1'b0;
        @(negedge clk);
        chk("release_write", 83'(fifo_in_valid), 83'(1));
        chk("release_ready", 83'(s_ready), 83'(1));
        tick();
        send(1'b0, 1'b1, 2'd0, 9'h042, pd[3]);
        drain_check("t4");

        // Back-to-back 2-beat packets
        wr_cyc.delete();
        exp_rdy = 1'b1;
        send_pkt(2, 9'h101, 2'd0, 1'b1);
        send_pkt(2, 9'h102, 2'd1, 1'b1);
        send_pkt(2, 9'h103, 2'd3, 1'b1);
        exp_rdy = 1'b0;
        drain_check("t5");
        chk("b2b_writes", 83'(wr_cyc.size()), 83'(3));
        if (wr_cyc.size() == 3) begin
            chk("b2b_gap0", 83'(wr_cyc[1] - wr_cyc[0]), 83'(2));
            chk("b2b_gap1", 83'(wr_cyc[2] - wr_cyc[1]), 83'(2));
        end

        // sop mid-packet: odd trailing beat discarded, new packet starts
        send_pkt(3, 9'h0c1, 2'd0, 1'b0);
        for (int i = 0; i < 2; i++) pd[i] = $urandom;
        model_push(2, 9'h0c2, 2'd1, 1'b1);
        exp_err++;
        send(1'b1, 1'b0, 2'd1, 9'h0c2, pd[0]);
        @(negedge clk);
        chk("err_sop_pulse", 83'(pkt_err), 83'(1));
        tick();
        send(1'b0, 1'b1, 2'd1, 9'h0c2, pd[1]);
        // data beat while idle: dropped
        exp_err++;
        send(1'b0, 1'b0, 2'd0, 9'h0c3, $urandom);
        @(negedge clk);
        chk("err_idle_pulse", 83'(pkt_err), 83'(1));
        tick();
        drain_check("t6");

        // Randomized traffic with random stalls; drives pkt_cnt into saturation
        for (int k = 0; k < 25; k++) begin
            int idle;
            stall_pct = $urandom_range(60);
            send_pkt($urandom_range(1, 7), 9'($urandom), 2'($urandom), 1'b1);
            idle = $urandom_range(2);
            for (int j = 0; j < idle; j++) tick();
        end
        drain_check("rand");

        // Reset with an entry held under stall and a packet open
        stall_pct = 100;
        fifo_in_stall = 1'b1;
        send(1'b1, 1'b0, 2'd0, 9'h077, $urandom);
        send(1'b0, 1'b0, 2'd0, 9'h077, $urandom);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_ready", 83'(s_ready), 83'(1));
        chk("mid_rst_fifo_in", fifo_in, 83'(0));
        chk("mid_rst_valid", 83'(fifo_in_valid), 83'(0));
        chk("mid_rst_pkt_err", 83'(pkt_err), 83'(0));
        chk("mid_rst_pkt_cnt", 83'(pkt_cnt), 83'(0));
        exp_pkts = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        stall_pct = 0;
        fifo_in_stall = 1'b0;
        tick();
        send_pkt(2, 9'h078, 2'd0, 1'b1);
        drain_check("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
